// File: rtl/flash_spi_ctrl_if.sv
// Z80-side register port of the flash SPI controller: register select,
// read/write strobes, write data and the combinational read-back path.
interface flash_spi_ctrl_if;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe_n;

    modport master (
        output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
        input  dout, oe_n
    );

    modport slave (
        input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
        output dout, oe_n
    );
endinterface

// File: rtl/flash_spi_ctrl.sv
// Memory-mapped SPI mode-0 master for the boot/config flash.
// Register FLASHSPI_ADDR: each access runs one 8-bit MSB-first transfer
// (writes send din, reads send 8'hFF and return the previous result).
// Register FLASHCS_ADDR: bit 0 drives flash_cs_n, bit 7 reads back busy.
module flash_spi_ctrl #(
    parameter logic [7:0]  FLASHSPI_ADDR = 8'h02,
    parameter logic [7:0]  FLASHCS_ADDR  = 8'h03,
    parameter int unsigned CLKDIV        = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    flash_spi_ctrl_if.slave    bus,
    output logic               flash_cs_n,
    output logic               flash_clk,
    output logic               flash_di,
    input  logic               flash_do,
    output logic               busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLKDIV - 1);

    state_t     state, state_d;
    logic       regrd_q, regwr_q;
    logic       wr_trig, rd_trig, cs_wr;
    logic [7:0] tx_byte;
    logic [7:0] shreg, shreg_d;
    logic [7:0] rxsh, rxsh_d;
    logic [7:0] rx_data, rx_data_d;
    logic [3:0] divcnt, divcnt_d;
    logic [4:0] toggles, toggles_d;
    logic       busy_d, flash_clk_d, flash_di_d, flash_cs_n_d;

    // One trigger per I/O access: only the rising edge of each strobe counts.
    assign wr_trig = bus.zxuno_regwr & ~regwr_q & (bus.zxuno_addr == FLASHSPI_ADDR);
    assign rd_trig = bus.zxuno_regrd & ~regrd_q & (bus.zxuno_addr == FLASHSPI_ADDR);
    assign cs_wr   = bus.zxuno_regwr & ~regwr_q & (bus.zxuno_addr == FLASHCS_ADDR);

    // Registered copies of the strobes for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regrd_q <= 1'b0;
            regwr_q <= 1'b0;
        end else begin
            regrd_q <= bus.zxuno_regrd;
            regwr_q <= bus.zxuno_regwr;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and SPI pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            shreg      <= '1;
            rxsh       <= '1;
            rx_data    <= '1;
            divcnt     <= '0;
            toggles    <= '0;
            flash_clk  <= 1'b0;
            flash_di   <= 1'b1;
            flash_cs_n <= 1'b1;
        end else begin
            busy       <= busy_d;
            shreg      <= shreg_d;
            rxsh       <= rxsh_d;
            rx_data    <= rx_data_d;
            divcnt     <= divcnt_d;
            toggles    <= toggles_d;
            flash_clk  <= flash_clk_d;
            flash_di   <= flash_di_d;
            flash_cs_n <= flash_cs_n_d;
        end
    end

    // Next-state logic: start on a trigger in IDLE, then 16 SCK half-periods.
    always_comb begin
        state_d      = state;
        busy_d       = busy;
        shreg_d      = shreg;
        rxsh_d       = rxsh;
        rx_data_d    = rx_data;
        divcnt_d     = divcnt;
        toggles_d    = toggles;
        flash_clk_d  = flash_clk;
        flash_di_d   = flash_di;
        flash_cs_n_d = cs_wr ? bus.din[0] : flash_cs_n;
        tx_byte      = wr_trig ? bus.din : 8'hFF;

        case (state)
            IDLE: begin
                if (wr_trig || rd_trig) begin
                    state_d     = SHIFT;
                    busy_d      = 1'b1;
                    shreg_d     = tx_byte;
                    flash_di_d  = tx_byte[7];
                    divcnt_d    = '0;
                    toggles_d   = '0;
                    flash_clk_d = 1'b0;
                end
            end
            SHIFT: begin
                if (divcnt == DIV_LAST) begin
                    divcnt_d    = '0;
                    flash_clk_d = ~flash_clk;
                    toggles_d   = toggles + 5'd1;
                    if (!flash_clk) begin
                        // Rising SCK: sample MISO.
                        rxsh_d = {rxsh[6:0], flash_do};
                    end else if (toggles == 5'd15) begin
                        // Final falling SCK: byte complete, MOSI back to idle high.
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        rx_data_d  = rxsh;
                        flash_di_d = 1'b1;
                    end else begin
                        // Falling SCK: present the next MOSI bit.
                        shreg_d    = {shreg[6:0], 1'b0};
                        flash_di_d = shreg[6];
                    end
                end else begin
                    divcnt_d = divcnt + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational read-back onto the CPU bus.
    always_comb begin
        bus.dout = 8'hFF;
        bus.oe_n = 1'b1;
        if (bus.zxuno_regrd && bus.zxuno_addr == FLASHSPI_ADDR) begin
            bus.dout = rx_data;
            bus.oe_n = 1'b0;
        end else if (bus.zxuno_regrd && bus.zxuno_addr == FLASHCS_ADDR) begin
            bus.dout = {busy, 6'b0, flash_cs_n};
            bus.oe_n = 1'b0;
        end
    end

endmodule
